// File: rtl/ws2812_edge_sync.sv
// WS2812 input front end: synchronizes and deglitches the raw serial line, reports
// accepted edges, measures high/low times and decodes bits once a frame gap has been seen.
module ws2812_edge_sync #(
   parameter int SYNC_STAGES       = 2,
   parameter int FILTER_CYCLES     = 3,
   parameter int BIT_THRESH_CYCLES = 30,
   parameter int RESET_CYCLES      = 2500,
   parameter int CNT_WIDTH         = 12
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_level,
   output logic o_rising,
   output logic o_falling,
   output logic o_bit_valid,
   output logic o_bit_value,
   output logic o_frame_reset
);

   localparam int FW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
   // The toggle is taken while the counter shows FILTER_CYCLES-1 so the level lands
   // exactly SYNC_STAGES+FILTER_CYCLES cycles after the raw edge.
   localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] LOW_SAT   = CNT_WIDTH'(RESET_CYCLES);
   localparam logic [CNT_WIDTH-1:0] BIT_THR   = CNT_WIDTH'(BIT_THRESH_CYCLES);

   typedef enum logic [1:0] {
      WAIT_GAP   = 2'd0,
      ARMED_LOW  = 2'd1,
      ARMED_HIGH = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FW-1:0]          filt_q, filt_d;
   logic                   level_q, level_d;
   logic                   rising_q, rising_d;
   logic                   falling_q, falling_d;
   logic [CNT_WIDTH-1:0]   high_q, high_d;
   logic [CNT_WIDTH-1:0]   low_q, low_d;
   state_t                 state_q, state_d;
   logic                   bit_valid_q, bit_valid_d;
   logic                   bit_value_q, bit_value_d;
   logic                   frame_q, frame_d;
   logic                   rise_ev, fall_ev;

   // Synchronizer shift and stability filter producing the accepted level.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], i_din};
      level_d = level_q;
      filt_d  = {FW{1'b0}};
      if (sync_q[SYNC_STAGES-1] != level_q) begin
         if (filt_q == FILT_LAST) begin
            level_d = ~level_q;
         end else begin
            filt_d = filt_q + FW'(1);
         end
      end else begin
         filt_d = {FW{1'b0}};
      end
      rise_ev   = level_d & ~level_q;
      fall_ev   = ~level_d & level_q;
      rising_d  = rise_ev;
      falling_d = fall_ev;
   end

   // High/low time counters and the single-shot frame-gap detector.
   always_comb begin
      high_d = high_q;
      low_d  = low_q;
      if (rise_ev) begin
         high_d = CNT_ONE;
      end else if (level_d && (high_q != CNT_MAX)) begin
         high_d = high_q + CNT_ONE;
      end else begin
         high_d = high_q;
      end
      if (fall_ev) begin
         low_d = CNT_ONE;
      end else if (!level_d && (low_q != LOW_SAT)) begin
         low_d = low_q + CNT_ONE;
      end else begin
         low_d = low_q;
      end
      frame_d = (low_d == LOW_SAT) && (low_q != LOW_SAT);
   end

   // Arming FSM and bit decode; high_q still holds the full high time on the fall event.
   always_comb begin
      state_d     = state_q;
      bit_valid_d = 1'b0;
      bit_value_d = 1'b0;
      if (frame_d) begin
         state_d = ARMED_LOW;
      end else begin
         case (state_q)
            WAIT_GAP: begin
               state_d = WAIT_GAP;
            end
            ARMED_LOW: begin
               if (rise_ev) begin
                  state_d = ARMED_HIGH;
               end else begin
                  state_d = ARMED_LOW;
               end
            end
            ARMED_HIGH: begin
               if (fall_ev) begin
                  state_d     = ARMED_LOW;
                  bit_valid_d = 1'b1;
                  bit_value_d = (high_q >= BIT_THR) || (high_q == CNT_MAX);
               end else begin
                  state_d = ARMED_HIGH;
               end
            end
            default: begin
               state_d = WAIT_GAP;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_q      <= {SYNC_STAGES{1'b0}};
         filt_q      <= {FW{1'b0}};
         level_q     <= 1'b0;
         rising_q    <= 1'b0;
         falling_q   <= 1'b0;
         high_q      <= {CNT_WIDTH{1'b0}};
         low_q       <= {CNT_WIDTH{1'b0}};
         state_q     <= WAIT_GAP;
         bit_valid_q <= 1'b0;
         bit_value_q <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         filt_q      <= filt_d;
         level_q     <= level_d;
         rising_q    <= rising_d;
         falling_q   <= falling_d;
         high_q      <= high_d;
         low_q       <= low_d;
         state_q     <= state_d;
         bit_valid_q <= bit_valid_d;
         bit_value_q <= bit_value_d;
         frame_q     <= frame_d;
      end
   end

   assign o_level       = level_q;
   assign o_rising      = rising_q;
   assign o_falling     = falling_q;
   assign o_bit_valid   = bit_valid_q;
   assign o_bit_value   = bit_value_q;
   assign o_frame_reset = frame_q;

endmodule

// File: tb/tb_ws2812_edge_sync.sv
// Self-checking bench for ws2812_edge_sync: expected events are queued when stimulus is
// driven and compared against events collected from the DUT outputs.
module tb_ws2812_edge_sync;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_din = 1'b0;
   logic o_level, o_rising, o_falling, o_bit_valid, o_bit_value, o_frame_reset;

   ws2812_edge_sync dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_din(i_din),
      .o_level(o_level), .o_rising(o_rising), .o_falling(o_falling),
      .o_bit_valid(o_bit_valid), .o_bit_value(o_bit_value), .o_frame_reset(o_frame_reset)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   bit armed_m = 1'b0;
   int last_fall = 0;

   // event word: {kind, cycle}; kinds 1 rise, 2 fall, 3 bit0, 4 bit1, 5 frame gap
   logic [35:0] exp_q[$];
   logic [35:0] obs_q[$];

   function automatic logic [35:0] ev(input int kind, input int c);
      return {4'(kind), 32'(c)};
   endfunction

   // Collect DUT output events away from the active edge.
   always @(negedge i_clk) begin
      if (o_rising)      obs_q.push_back(ev(1, cyc));
      if (o_falling)     obs_q.push_back(ev(2, cyc));
      if (o_bit_valid)   obs_q.push_back(ev(o_bit_value ? 4 : 3, cyc));
      if (o_frame_reset) obs_q.push_back(ev(5, cyc));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // One high pulse of h cycles then l low cycles, with its expected events.
   task automatic send_bit(input int h, input int l);
      int t0;
      t0 = cyc;
      i_din = 1'b1;
      exp_q.push_back(ev(1, t0 + 5));
      tick(h);
      i_din = 1'b0;
      exp_q.push_back(ev(2, cyc + 5));
      if (armed_m) exp_q.push_back(ev(((cyc - t0) >= 30) ? 4 : 3, cyc + 5));
      last_fall = cyc + 5;
      tick(l);
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_din = i[0];
         tick(3);
         total++;
         if ({o_level, o_rising, o_falling, o_bit_valid, o_bit_value, o_frame_reset} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {o_level, o_rising, o_falling, o_bit_valid, o_bit_value, o_frame_reset});
         end
      end
      i_din = 1'b0;
      tick(4);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_gap;
      logic [35:0] e, o;
      i_reset = 1'b0;
      exp_q.push_back(ev(5, cyc + 2500));
      armed_m = 1'b1;
      tick(3000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL gap_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", o[35:32], o[31:0], e[35:32], e[31:0]);
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL gap_extra: got %0d extra events expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_bits;
      logic [35:0] e, o;
      send_bit(20, 30);
      send_bit(40, 30);
      send_bit(30, 30);
      send_bit(29, 30);
      send_bit(31, 30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL bits_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", o[35:32], o[31:0], e[35:32], e[31:0]);
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL bits_extra: got %0d extra events expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_glitch;
      logic [35:0] e, o;
      int t0;
      // short high glitches on a low line
      for (int w = 1; w <= 2; w++) begin
         i_din = 1'b1;
         tick(w);
         i_din = 1'b0;
         tick(20);
         total++;
         if (o_level !== 1'b0) begin
            bad++;
            $display("FAIL glitch_high_level: got %b expected 0", o_level);
         end
      end
      // short low glitches inside one long high pulse
      t0 = cyc;
      i_din = 1'b1;
      exp_q.push_back(ev(1, t0 + 5));
      tick(10);
      i_din = 1'b0; tick(1); i_din = 1'b1; tick(10);
      i_din = 1'b0; tick(2); i_din = 1'b1; tick(10);
      total++;
      if (o_level !== 1'b1) begin
         bad++;
         $display("FAIL glitch_low_level: got %b expected 1", o_level);
      end
      i_din = 1'b0;
      exp_q.push_back(ev(2, cyc + 5));
      exp_q.push_back(ev(((cyc - t0) >= 30) ? 4 : 3, cyc + 5));
      tick(30);
      // a 3-cycle pulse is long enough to be accepted
      send_bit(3, 30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL glitch_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", o[35:32], o[31:0], e[35:32], e[31:0]);
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL glitch_extra: got %0d extra events expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      logic [35:0] e, o;
      logic [23:0] pattern;
      pattern = 24'hA5C396;
      i_reset = 1'b1;
      armed_m = 1'b0;
      tick(5);
      obs_q.delete();
      i_reset = 1'b0;
      tick(10);
      for (int i = 23; i >= 0; i--) send_bit(pattern[i] ? 40 : 20, 30);
      exp_q.push_back(ev(5, last_fall + 2499));
      armed_m = 1'b1;
      tick(2600);
      for (int i = 23; i >= 0; i--) send_bit(pattern[i] ? 40 : 20, 30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL b2b_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", o[35:32], o[31:0], e[35:32], e[31:0]);
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_extra: got %0d extra events expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid_pulse;
      logic [35:0] e, o;
      i_din = 1'b1;
      exp_q.push_back(ev(1, cyc + 5));
      tick(10);
      total++;
      if (o_level !== 1'b1) begin
         bad++;
         $display("FAIL midrst_level_before: got %b expected 1", o_level);
      end
      #2;
      i_reset = 1'b1;
      armed_m = 1'b0;
      #1;
      total++;
      if ({o_level, o_rising, o_falling, o_bit_valid, o_bit_value, o_frame_reset} !== 6'b0) begin
         bad++;
         $display("FAIL midrst_outputs: got %b expected 000000",
                  {o_level, o_rising, o_falling, o_bit_valid, o_bit_value, o_frame_reset});
      end
      tick(30);
      i_din = 1'b0;
      tick(10);
      i_reset = 1'b0;
      exp_q.push_back(ev(5, cyc + 2500));
      armed_m = 1'b1;
      tick(2600);
      send_bit(40, 30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL midrst_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d", o[35:32], o[31:0], e[35:32], e[31:0]);
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL midrst_extra: got %0d extra events expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_gap();
      test_bits();
      test_glitch();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
